fetch_seq: RTL and testbench

FETCH_SEQ -- requirements
Module: fetch_seq

---
 rtl/fetch_seq.sv | 213 +++++++++++++++++++++
 tb/tb_fetch_seq.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// Byte-serial instruction fetch: reads one byte per memory handshake, decodes
// icode/ifun/rA/rB/valC and reports valP and a status code on a one-cycle done pulse.
module fetch_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] PC,
   input  logic        start,
   output logic        mem_req,
   output logic [63:0] mem_addr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_err,
   output logic        busy,
   output logic        done,
   output logic [3:0]  icode,
   output logic [3:0]  ifun,
   output logic [3:0]  rA,
   output logic [3:0]  rB,
   output logic [63:0] valC,
   output logic [63:0] valP,
   output logic [2:0]  stat
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;
   typedef enum logic [2:0] {
      ST_AOK = 3'd1,
      ST_HLT = 3'd2,
      ST_ADR = 3'd3,
      ST_INS = 3'd4
   } stat_t;

   function automatic logic [3:0] insn_len(input logic [3:0] ic);
      case (ic)
         4'h0, 4'h1, 4'h9:       insn_len = 4'd1;
         4'h2, 4'h6, 4'hA, 4'hB: insn_len = 4'd2;
         4'h7, 4'h8:             insn_len = 4'd9;
         4'h3, 4'h4, 4'h5:       insn_len = 4'd10;
         default:                insn_len = 4'd1;
      endcase
   endfunction

   function automatic logic insn_ok(input logic [3:0] ic, input logic [3:0] fn);
      case (ic)
         4'h2, 4'h7:                    insn_ok = (fn <= 4'd6);
         4'h6:                          insn_ok = (fn <= 4'd3);
         4'hC, 4'hD, 4'hE, 4'hF:        insn_ok = 1'b0;
         default:                       insn_ok = (fn == 4'd0);
      endcase
   endfunction

   function automatic logic has_reg(input logic [3:0] ic);
      case (ic)
         4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_reg = 1'b1;
         default:                                  has_reg = 1'b0;
      endcase
   endfunction

   function automatic logic has_valc(input logic [3:0] ic);
      case (ic)
         4'h3, 4'h4, 4'h5, 4'h7, 4'h8: has_valc = 1'b1;
         default:                      has_valc = 1'b0;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic [63:0] base_q, base_d;
   logic [3:0]  idx_q, idx_d;
   // working copies of the fields while bytes arrive
   logic [3:0]  w_icode_q, w_icode_d, w_ifun_q, w_ifun_d;
   logic [3:0]  w_ra_q, w_ra_d, w_rb_q, w_rb_d;
   logic [63:0] w_valc_q, w_valc_d;
   logic [3:0]  icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
   logic [63:0] valc_q, valc_d, valp_q, valp_d;
   stat_t       stat_q, stat_d;

   logic [3:0]  cur_icode, cur_ifun, cur_len;
   logic [2:0]  vc_start, vc_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         base_q    <= '0;
         idx_q     <= '0;
         w_icode_q <= '0;
         w_ifun_q  <= '0;
         w_ra_q    <= '1;
         w_rb_q    <= '1;
         w_valc_q  <= '0;
         icode_q   <= '0;
         ifun_q    <= '0;
         ra_q      <= '1;
         rb_q      <= '1;
         valc_q    <= '0;
         valp_q    <= '0;
         stat_q    <= ST_AOK;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         idx_q     <= idx_d;
         w_icode_q <= w_icode_d;
         w_ifun_q  <= w_ifun_d;
         w_ra_q    <= w_ra_d;
         w_rb_q    <= w_rb_d;
         w_valc_q  <= w_valc_d;
         icode_q   <= icode_d;
         ifun_q    <= ifun_d;
         ra_q      <= ra_d;
         rb_q      <= rb_d;
         valc_q    <= valc_d;
         valp_q    <= valp_d;
         stat_q    <= stat_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      idx_d     = idx_q;
      w_icode_d = w_icode_q;
      w_ifun_d  = w_ifun_q;
      w_ra_d    = w_ra_q;
      w_rb_d    = w_rb_q;
      w_valc_d  = w_valc_q;
      icode_d   = icode_q;
      ifun_d    = ifun_q;
      ra_d      = ra_q;
      rb_d      = rb_q;
      valc_d    = valc_q;
      valp_d    = valp_q;
      stat_d    = stat_q;

      // byte 0 is decoded straight off the bus so length is known on its ack
      cur_icode = (idx_q == 4'd0) ? mem_rdata[7:4] : w_icode_q;
      cur_ifun  = (idx_q == 4'd0) ? mem_rdata[3:0] : w_ifun_q;
      cur_len   = insn_len(cur_icode);
      vc_start  = (cur_icode == 4'h7 || cur_icode == 4'h8) ? 3'd1 : 3'd2;
      vc_idx    = idx_q[2:0] - vc_start;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_FETCH;
               base_d    = PC;
               idx_d     = '0;
               w_icode_d = '0;
               w_ifun_d  = '0;
               w_ra_d    = '1;
               w_rb_d    = '1;
               w_valc_d  = '0;
            end
         end
         S_FETCH: begin
            if (mem_ack) begin
               if (mem_err) begin
                  state_d = S_DONE;
                  icode_d = w_icode_q;
                  ifun_d  = w_ifun_q;
                  ra_d    = w_ra_q;
                  rb_d    = w_rb_q;
                  valc_d  = w_valc_q;
                  valp_d  = base_q + ((idx_q == 4'd0) ? 64'd1 : {60'd0, insn_len(w_icode_q)});
                  stat_d  = ST_ADR;
               end else if (idx_q == 4'd0 && !insn_ok(cur_icode, cur_ifun)) begin
                  state_d = S_DONE;
                  icode_d = cur_icode;
                  ifun_d  = cur_ifun;
                  ra_d    = '1;
                  rb_d    = '1;
                  valc_d  = '0;
                  valp_d  = base_q + 64'd1;
                  stat_d  = ST_INS;
               end else begin
                  w_icode_d = cur_icode;
                  w_ifun_d  = cur_ifun;
                  if (idx_q == 4'd1 && has_reg(cur_icode)) begin
                     w_ra_d = mem_rdata[7:4];
                     w_rb_d = mem_rdata[3:0];
                  end else if (has_valc(cur_icode) && idx_q >= {1'b0, vc_start}) begin
                     w_valc_d[{vc_idx, 3'b000} +: 8] = mem_rdata;
                  end
                  if (idx_q == cur_len - 4'd1) begin
                     state_d = S_DONE;
                     icode_d = cur_icode;
                     ifun_d  = cur_ifun;
                     ra_d    = w_ra_d;
                     rb_d    = w_rb_d;
                     valc_d  = w_valc_d;
                     valp_d  = base_q + {60'd0, cur_len};
                     stat_d  = (cur_icode == 4'h0) ? ST_HLT : ST_AOK;
                  end else begin
                     idx_d = idx_q + 4'd1;
                  end
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign mem_req  = (state_q == S_FETCH);
   assign busy     = (state_q == S_FETCH);
   assign done     = (state_q == S_DONE);
   assign mem_addr = mem_req ? (base_q + {60'd0, idx_q}) : '0;
   assign icode    = icode_q;
   assign ifun     = ifun_q;
   assign rA       = ra_q;
   assign rB       = rb_q;
   assign valC     = valc_q;
   assign valP     = valp_q;
   assign stat     = stat_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: a byte memory with configurable wait states and
// faults, a rule-level result model, and a per-cycle compare process.
module tb_fetch_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] PC;
   logic        start;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic        mem_err;
   logic        busy;
   logic        done;
   logic [3:0]  icode, ifun, rA, rB;
   logic [63:0] valC, valP;
   logic [2:0]  stat;

   always #5 clk = ~clk;

   fetch_seq dut (
      .clk(clk), .rst_n(rst_n), .PC(PC), .start(start),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .mem_err(mem_err), .busy(busy), .done(done),
      .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
      .valC(valC), .valP(valP), .stat(stat)
   );

   typedef struct {
      logic [3:0]  icode, ifun, ra, rb;
      logic [63:0] valc, valp;
      logic [2:0]  stat;
      bit          ifk;
      int          nreads;
   } res_t;

   logic [7:0]  mem [logic [63:0]];
   logic [63:0] err_addr = '0;
   bit          err_en = 1'b0;
   int          ack_delay = 0;
   bit          stray = 1'b0;
   logic [63:0] addr_log [$];
   int          checks = 0;
   int          errors = 0;
   res_t        exp_r, hold_r, rst_r;
   logic [63:0] cur_base = '0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, expv);
      end
   endtask

   function automatic logic [146:0] fv(input logic [3:0] ic, input logic [3:0] fn,
                                       input logic [3:0] ra, input logic [3:0] rb,
                                       input logic [63:0] vc, input logic [63:0] vp,
                                       input logic [2:0] st, input bit ifk);
      return {ifk ? ic : 4'h0, ifk ? fn : 4'h0, ra, rb, vc, vp, st};
   endfunction

   function automatic logic [146:0] fv_r(input res_t r);
      return fv(r.icode, r.ifun, r.ra, r.rb, r.valc, r.valp, r.stat, r.ifk);
   endfunction

   function automatic logic [146:0] fv_dut(input bit ifk);
      return fv(icode, ifun, rA, rB, valC, valP, stat, ifk);
   endfunction

   function automatic logic [7:0] mem_rd(input logic [63:0] a);
      return mem.exists(a) ? mem[a] : 8'h00;
   endfunction

   // Result derived from the instruction-set rules over the memory image.
   function automatic res_t model(input logic [63:0] base);
      res_t r;
      logic [7:0] b;
      int len, off;
      bit bad, reg_byte;
      r.icode = 4'h0; r.ifun = 4'h0; r.ra = 4'hF; r.rb = 4'hF;
      r.valc = '0; r.ifk = 1'b0; r.nreads = 1;
      if (err_en && err_addr == base) begin
         r.stat = 3'd3; r.valp = base + 64'd1;
         return r;
      end
      b = mem_rd(base);
      r.icode = b[7:4]; r.ifun = b[3:0]; r.ifk = 1'b1;
      case (r.icode)
         4'h0, 4'h1, 4'h9:       len = 1;
         4'h2, 4'h6, 4'hA, 4'hB: len = 2;
         4'h7, 4'h8:             len = 9;
         4'h3, 4'h4, 4'h5:       len = 10;
         default:                len = 0;
      endcase
      bad = (len == 0);
      if (r.icode == 4'h2 || r.icode == 4'h7) bad = bad || (r.ifun > 4'd6);
      else if (r.icode == 4'h6)               bad = bad || (r.ifun > 4'd3);
      else                                    bad = bad || (r.ifun != 4'd0);
      if (bad) begin
         r.stat = 3'd4; r.valp = base + 64'd1;
         return r;
      end
      r.valp = base + 64'(len);
      reg_byte = (len == 2 || len == 10);
      off = reg_byte ? 2 : 1;
      for (int i = 1; i < len; i++) begin
         r.nreads = i + 1;
         if (err_en && err_addr == base + 64'(i)) begin
            r.stat = 3'd3;
            return r;
         end
         b = mem_rd(base + 64'(i));
         if (reg_byte && i == 1) begin
            r.ra = b[7:4]; r.rb = b[3:0];
         end else begin
            r.valc = r.valc | (64'(b) << (8 * (i - off)));
         end
      end
      r.stat = (r.icode == 4'h0) ? 3'd2 : 3'd1;
      r.nreads = len;
      return r;
   endfunction

   // Memory responder: acks after ack_delay idle cycles, logs every acked address.
   int wcnt = 0;
   always begin
      @(posedge clk); #2;
      mem_ack = 1'b0; mem_err = 1'b0;
      if (rst_n && mem_req) begin
         if (wcnt >= ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_rd(mem_addr);
            mem_err   = err_en && (mem_addr == err_addr);
            addr_log.push_back(mem_addr);
            wcnt = 0;
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
         if (stray) begin
            mem_ack = 1'b1; mem_rdata = 8'h30;
         end
      end
   end

   // Per-cycle compare against the model and the held result.
   int n_acked = 0;
   bit in_fetch = 1'b0;
   bit expect_done = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_ctl", {mem_req, busy, done, mem_addr}, '0);
         chk("rst_fields", fv_dut(1'b1), fv_r(rst_r));
         hold_r = rst_r; in_fetch = 1'b0; expect_done = 1'b0; n_acked = 0;
      end else begin
         chk("busy_vs_req", busy, mem_req);
         if (mem_req) begin
            if (!in_fetch) begin
               in_fetch = 1'b1; n_acked = 0;
            end
            chk("mem_addr", mem_addr, cur_base + 64'(n_acked));
            chk("read_count", n_acked < exp_r.nreads, 1'b1);
            if (mem_ack) n_acked++;
         end else begin
            in_fetch = 1'b0;
         end
         chk("done", done, expect_done);
         if (done) begin
            chk("result", fv_dut(exp_r.ifk), fv_r(exp_r));
            hold_r = exp_r;
         end else begin
            chk("hold", fv_dut(hold_r.ifk), fv_r(hold_r));
         end
         expect_done = mem_req && mem_ack && (n_acked == exp_r.nreads);
      end
   end

   task automatic load(input logic [63:0] base, input logic [79:0] bytes, input int n);
      mem.delete();
      for (int i = 0; i < n; i++) mem[base + 64'(i)] = bytes[(n - 1 - i) * 8 +: 8];
   endtask

   task automatic run_fetch(input logic [63:0] base, input int dly, input int poke, output int lat);
      @(posedge clk); #2;
      exp_r = model(base); cur_base = base; ack_delay = dly; addr_log.delete();
      PC = base; start = 1'b1; lat = 0;
      while (lat < 400) begin
         @(posedge clk); #2;
         lat++;
         start = (lat == poke);
         PC = (lat == poke) ? 64'h500 : 64'h0;
         if (done) break;
      end
      start = 1'b0;
      chk("done_seen", done, 1'b1);
   endtask

   int lat;
   bit ok;
   initial begin
      rst_r.icode = 4'h0; rst_r.ifun = 4'h0; rst_r.ra = 4'hF; rst_r.rb = 4'hF;
      rst_r.valc = '0; rst_r.valp = '0; rst_r.stat = 3'd1; rst_r.ifk = 1'b1; rst_r.nreads = 1;
      exp_r = rst_r; hold_r = rst_r;
      rst_n = 1'b1; start = 1'b0; PC = '0;
      mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("reset_ctl", {mem_req, busy, done, mem_addr}, '0);
      chk("reset_fields", fv_dut(1'b1), fv(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1, 1'b1));
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;

      // irmovq-class 10-byte fetch, zero wait states
      load(64'h100, 80'h30F2EFCDAB8967452301, 10);
      run_fetch(64'h100, 0, -1, lat);
      chk("t1_latency", lat, 11);
      chk("t1_fields", fv_dut(1'b1), fv(4'h3, 4'h0, 4'hF, 4'h2, 64'h0123456789ABCDEF, 64'h10A, 3'd1, 1'b1));
      chk("t1_nreads", addr_log.size(), 10);
      ok = 1'b1;
      foreach (addr_log[i]) ok = ok && (addr_log[i] == 64'h100 + 64'(i));
      chk("t1_addrs", ok, 1'b1);

      // 9-byte jump, three wait states per byte
      load(64'h0, 80'h744000000000000000, 9);
      run_fetch(64'h0, 3, -1, lat);
      chk("t2_latency", lat, 37);
      chk("t2_fields", fv_dut(1'b1), fv(4'h7, 4'h4, 4'hF, 4'hF, 64'h40, 64'h9, 3'd1, 1'b1));

      // one-byte ret
      load(64'h20, 80'h90, 1);
      run_fetch(64'h20, 0, -1, lat);
      chk("t3_latency", lat, 2);
      chk("t3_fields", fv_dut(1'b1), fv(4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h21, 3'd1, 1'b1));

      // illegal icode and illegal ifun
      load(64'h30, 80'hC0, 1);
      run_fetch(64'h30, 0, -1, lat);
      chk("t4_latency", lat, 2);
      chk("t4_fields", fv_dut(1'b1), fv(4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h31, 3'd4, 1'b1));
      load(64'h40, 80'h11, 1);
      run_fetch(64'h40, 0, -1, lat);
      chk("t4b_fields", fv_dut(1'b1), fv(4'h1, 4'h1, 4'hF, 4'hF, 64'h0, 64'h41, 3'd4, 1'b1));
      load(64'h60, 80'h6400, 2);
      run_fetch(64'h60, 0, -1, lat);
      chk("t4c_fields", fv_dut(1'b1), fv(4'h6, 4'h4, 4'hF, 4'hF, 64'h0, 64'h61, 3'd4, 1'b1));

      // halt
      load(64'h50, 80'h00, 1);
      run_fetch(64'h50, 0, -1, lat);
      chk("t5_fields", fv_dut(1'b1), fv(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h51, 3'd2, 1'b1));

      // rmmovq with fault on the third byte
      load(64'h8, 80'h4012AAAAAAAAAAAAAAAA, 10);
      err_en = 1'b1; err_addr = 64'hA;
      run_fetch(64'h8, 0, -1, lat);
      err_en = 1'b0;
      chk("t6_latency", lat, 4);
      chk("t6_nreads", addr_log.size(), 3);
      chk("t6_fields", fv_dut(1'b1), fv(4'h4, 4'h0, 4'h1, 4'h2, 64'h0, 64'h12, 3'd3, 1'b1));

      // fault on byte 0: length unknown
      load(64'h200, 80'h30, 1);
      err_en = 1'b1; err_addr = 64'h200;
      run_fetch(64'h200, 0, -1, lat);
      err_en = 1'b0;
      chk("t7_fields", fv_dut(1'b0), fv(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h201, 3'd3, 1'b0));

      // valP wraps past the top of the address space; pushq
      load(64'hFFFF_FFFF_FFFF_FFFE, 80'h6012, 2);
      run_fetch(64'hFFFF_FFFF_FFFF_FFFE, 0, -1, lat);
      chk("t8_fields", fv_dut(1'b1), fv(4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h0, 3'd1, 1'b1));
      load(64'h70, 80'hA02F, 2);
      run_fetch(64'h70, 0, -1, lat);
      chk("t8b_fields", fv_dut(1'b1), fv(4'hA, 4'h0, 4'h2, 4'hF, 64'h0, 64'h72, 3'd1, 1'b1));

      // start pulsed mid-fetch is ignored
      load(64'h100, 80'h30F2EFCDAB8967452301, 10);
      run_fetch(64'h100, 1, 3, lat);
      chk("t9_latency", lat, 21);
      chk("t9_fields", fv_dut(1'b1), fv(4'h3, 4'h0, 4'hF, 4'h2, 64'h0123456789ABCDEF, 64'h10A, 3'd1, 1'b1));
      repeat (2) @(posedge clk);
      #2 chk("t9_no_restart", mem_req, 1'b0);

      // stray acks while idle
      stray = 1'b1;
      repeat (3) @(posedge clk);
      #2 stray = 1'b0;
      chk("t10_idle", {mem_req, done}, 2'b00);
      chk("t10_hold", fv_dut(1'b1), fv(4'h3, 4'h0, 4'hF, 4'h2, 64'h0123456789ABCDEF, 64'h10A, 3'd1, 1'b1));

      // reset in the middle of a fetch
      @(posedge clk); #2;
      exp_r = model(64'h100); cur_base = 64'h100; ack_delay = 1;
      PC = 64'h100; start = 1'b1;
      @(posedge clk); #2 start = 1'b0; PC = '0;
      repeat (3) @(posedge clk);
      #1 chk("t11_busy_before", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t11_abort_ctl", {mem_req, busy, done, mem_addr}, '0);
      chk("t11_abort_fields", fv_dut(1'b1), fv(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1, 1'b1));
      @(posedge clk); #3 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #2 chk("t11_idle_after", mem_req, 1'b0);
      load(64'h20, 80'h90, 1);
      run_fetch(64'h20, 0, -1, lat);
      chk("t11_refetch", fv_dut(1'b1), fv(4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h21, 3'd1, 1'b1));

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
